// File: rtl/shift_pkg.sv
// Shared FSM encoding and sizing helper for the sequential left shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Counter must be able to hold the value SHIFT itself.
  function automatic int cnt_width(input int shift);
    return $clog2(shift + 1);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Shift-step counter: synchronous clear/enable, terminal count flags the last step.
module shift_counter #(
  parameter int W    = 2,
  parameter int TERM = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // High while the step that completes shift number TERM is pending.
  assign tc = (count_reg == LAST);

endmodule

// File: rtl/shift_s_5_bit_left_2_bit.sv
// Multi-cycle left shifter (mul = d * 2^SHIFT mod 2^WIDTH), one bit per clock.
// Optional overflow flag output when SHIFT_OVERFLOW_EN is defined.
module shift_s_5_bit_left_2_bit
  import shift_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] mul,
  output logic             sout
`ifdef SHIFT_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(SHIFT);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mul_reg;
  logic             sout_reg;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             load, shift_en;

  shift_counter #(
    .W    (CNT_W),
    .TERM (SHIFT)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_SHIFT;
          cnt_clr    = 1'b1;
        end
      end
      S_SHIFT: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;  // unused code 2'd3 recovers
    endcase
  end

  assign load     = (state_reg == S_IDLE) && start;
  assign shift_en = (state_reg == S_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      mul_reg   <= '0;
      sout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        mul_reg <= d;
      end else if (shift_en) begin
        mul_reg  <= {mul_reg[WIDTH-2:0], 1'b0};
        sout_reg <= mul_reg[WIDTH-1];
      end
    end
  end

`ifdef SHIFT_OVERFLOW_EN
  logic ovf_reg;

  // Sticky OR of every bit pushed out of the MSB during one operation.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      ovf_reg <= 1'b0;
    end else if (shift_en) begin
      ovf_reg <= ovf_reg | mul_reg[WIDTH-1];
    end
  end

  assign ovf = ovf_reg;
`endif

  assign ready = (state_reg == S_IDLE);
  assign busy  = (state_reg == S_SHIFT);
  assign valid = (state_reg == S_DONE);
  assign mul   = mul_reg;
  assign sout  = sout_reg;

endmodule

// File: tb/tb_shift_s_5_bit_left_2_bit.sv
// Scoreboard bench for the sequential left shifter (default and SHIFT=5 builds).
module tb_shift_s_5_bit_left_2_bit;

  localparam int W  = 5;
  localparam int SH = 2;

  typedef struct {
    logic [4:0] d;
    logic [4:0] mul;
    logic       sout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] d = '0;
  logic       ready, busy, valid, sout, ovf;
  logic [4:0] mul;

  logic       start5 = 1'b0;
  logic [4:0] d5 = '0;
  logic       ready5, busy5, valid5, sout5, ovf5;
  logic [4:0] mul5;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   valid_cycles[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_s_5_bit_left_2_bit #(.WIDTH(W), .SHIFT(SH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .d(d),
    .ready(ready), .busy(busy), .valid(valid), .mul(mul), .sout(sout)
`ifdef SHIFT_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  shift_s_5_bit_left_2_bit #(.WIDTH(W), .SHIFT(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .d(d5),
    .ready(ready5), .busy(busy5), .valid(valid5), .mul(mul5), .sout(sout5)
`ifdef SHIFT_OVERFLOW_EN
    , .ovf(ovf5)
`endif
  );

`ifndef SHIFT_OVERFLOW_EN
  assign ovf  = 1'b0;
  assign ovf5 = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: full-precision product, then split into kept and shifted-out parts.
  function automatic exp_t model(input logic [4:0] dv, input int sh, input int c0);
    exp_t e;
    longint p;
    p      = longint'(dv) * (longint'(1) << sh);
    e.d    = dv;
    e.mul  = 5'(p % 32);
    e.sout = ((p / 32) % 2) != 0;
    e.ovf  = (p >= 32);
    e.cyc  = c0 + sh;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: valid=1 with no pending op, mul=%b", mul);
      end else begin
        exp_t e;
        e = sb.pop_front();
        valid_cycles.push_back(cyc);
        $display("txn d=%b mul=%b sout=%b ovf=%b cyc=%0d", e.d, mul, sout, ovf, cyc);
        chk("mul", int'(mul), int'(e.mul));
        chk("sout", int'(sout), int'(e.sout));
        chk("latency", cyc, e.cyc);
`ifdef SHIFT_OVERFLOW_EN
        chk("ovf", int'(ovf), int'(e.ovf));
`endif
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!ready) chk("ready_timeout", int'(ready), 1);
  endtask

  task automatic issue_op(input logic [4:0] dv);
    wait_ready();
    start = 1'b1;
    d     = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    d     = 5'($urandom);
    sb.push_back(model(dv, SH, cyc));
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] dv;
    int n, g;

    // Reset state, during and after reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_mul", int'(mul), 0);
    chk("rst_sout", int'(sout), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(ready), 1);
    chk("post_rst_valid", int'(valid), 0);

    // Directed: 00111 and 01001 (with mid-operation sout)
    issue_op(5'b00111);
    drain();
    issue_op(5'b01001);
    @(negedge clk);
    chk("sout_first_shift", int'(sout), 0);
    chk("busy_mid", int'(busy), 1);
    drain();

    // Sweep all operands
    for (int i = 0; i < 32; i++) begin
      issue_op(5'(i));
      drain();
    end

    // Random operands
    for (int i = 0; i < 20; i++) begin
      issue_op(5'($urandom));
      drain();
    end

    // Start held high: back-to-back ops, d scrambled while busy
    valid_cycles.delete();
    wait_ready();
    start = 1'b1;
    n = 0;
    g = 0;
    while (n < 3 && g < 40) begin
      g++;
      if (ready) begin
        dv = 5'($urandom);
        d  = dv;
        @(posedge clk);
        #1;
        sb.push_back(model(dv, SH, cyc));
        n++;
        if (n == 3) start = 1'b0;
        d = 5'($urandom);
      end else begin
        d = 5'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    chk("b2b_count", valid_cycles.size(), 3);
    if (valid_cycles.size() == 3) begin
      chk("b2b_period1", valid_cycles[1] - valid_cycles[0], SH + 2);
      chk("b2b_period2", valid_cycles[2] - valid_cycles[1], SH + 2);
    end

    // Reset one cycle after start aborts the operation
    wait_ready();
    start = 1'b1;
    d     = 5'b10110;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mul", int'(mul), 0);
    chk("abort_sout", int'(sout), 0);
    chk("abort_ovf", int'(ovf), 0);
    repeat (6) @(negedge clk);
    chk("abort_no_valid_pending", sb.size(), 0);

    // SHIFT=5 instance: every bit shifted out
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      int c0;
      dv = (k == 0) ? 5'b10101 : 5'($urandom);
      g = 0;
      @(negedge clk);
      while (!ready5 && g < 20) begin
        @(negedge clk);
        g++;
      end
      start5 = 1'b1;
      d5     = dv;
      @(posedge clk);
      #1;
      start5 = 1'b0;
      d5     = 5'($urandom);
      c0 = cyc;
      e  = model(dv, 5, c0);
      g  = 0;
      @(negedge clk);
      while (!valid5 && g < 20) begin
        @(negedge clk);
        g++;
      end
      $display("txn5 d=%b mul=%b sout=%b ovf=%b cyc=%0d", dv, mul5, sout5, ovf5, cyc);
      chk("s5_valid", int'(valid5), 1);
      chk("s5_latency", cyc, e.cyc);
      chk("s5_mul", int'(mul5), int'(e.mul));
      chk("s5_sout", int'(sout5), int'(e.sout));
`ifdef SHIFT_OVERFLOW_EN
      chk("s5_ovf", int'(ovf5), int'(e.ovf));
`endif
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_s_5_bit_left_2_bit.md
SHIFT_S_5_BIT_LEFT_2_BIT -- requirements
Module: shift_s_5_bit_left_2_bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning data width in bits.
REQ-002 The block SHALL have parameter SHIFT, default 2, meaning left-shift distance; legal range 1..WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to load d and begin shifting.
REQ-006 The block SHALL have port d, input, WIDTH bits: operand sampled with start.
REQ-007 The block SHALL have port ready, output, 1 bit: high in IDLE, meaning start will be accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high in SHIFT.
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse, meaning mul holds the new result.
REQ-010 The block SHALL have port mul, output, WIDTH bits: working register, equal to d*2^SHIFT mod 2^WIDTH once valid.
REQ-011 The block SHALL have port sout, output, 1 bit: the bit shifted out of the MSB on the most recent shift edge.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 SHALL load d into mul, clear the shift counter and go to SHIFT on the same edge.
REQ-014 In SHIFT, each edge SHALL perform mul <= {mul[WIDTH-2:0],1'b0} and sout <= mul[WIDTH-1], and SHALL increment the counter.
REQ-015 The edge performing shift number SHIFT SHALL move the FSM to DONE; the counter SHALL be ceil(log2(SHIFT+1)) bits wide.
REQ-016 DONE SHALL last exactly one cycle with valid=1, then return to IDLE unconditionally.
REQ-017 Latency: with start sampled at edge 0, valid SHALL be high in the cycle following edge SHIFT (default: after edge 2).
REQ-018 start SHALL be ignored outside IDLE, and d SHALL be don't-care outside the load edge.
REQ-019 mul and sout SHALL hold their values from DONE until the next accepted start.
REQ-020 With start held high continuously, operations SHALL run back-to-back with a period of SHIFT+2 cycles.
REQ-021 SHIFT=WIDTH SHALL yield mul=0 at valid.

Reset
REQ-022 When rst=1 at an edge, the block SHALL go to IDLE and clear mul, sout, the counter and ovf, overriding start.
REQ-023 Output values during and after reset SHALL be: ready=1, busy=0, valid=0.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation, and no valid pulse SHALL follow.

Configuration
REQ-025 When macro SHIFT_OVERFLOW_EN is defined, the block SHALL add output port ovf (1 bit).
REQ-026 With SHIFT_OVERFLOW_EN defined, ovf SHALL be cleared on load, OR-accumulate every bit shifted out, and hold until the next load.
REQ-027 With SHIFT_OVERFLOW_EN defined, ovf=1 at valid SHALL indicate that d*2^SHIFT did not fit in WIDTH bits.
REQ-028 Without SHIFT_OVERFLOW_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in shared package shift_pkg; 2'd3 SHALL recover to IDLE.
REQ-030 The block SHALL use one sub-module, shift_counter, holding the parameterised counter with clear, enable and terminal-count outputs.

Verification
REQ-031 The bench SHALL cover: d=5'b00111, start pulse -> valid 3 cycles after the start edge, mul=5'b11100, ovf=0, sout=0.
REQ-032 The bench SHALL cover: d=5'b01001 -> mul=5'b00100, sout sequence 0 then 1, ovf=1.
REQ-033 The bench SHALL cover: all 32 values of d, one at a time -> mul == (d<<2)&5'h1F, and ovf == (d[4]|d[3]).
REQ-034 The bench SHALL cover: start held high over 3 operations -> valid pulses every 4 cycles, and start ignored while busy=1.
REQ-035 The bench SHALL cover: rst asserted one cycle after start -> next cycle ready=1, mul=0, no valid pulse.
REQ-036 The bench SHALL cover: a rebuild with SHIFT=5 and d=5'b10101 -> mul=0, ovf=1.
